// File: rtl/mmio_debug_periph.sv
// rtl/mmio_debug_periph.sv - memory-mapped debug peripheral: console FIFOs, tick timer, status, halt
// Snoops the core data bus; console bytes leave on per-channel valid/ready streams.
module mmio_debug_periph #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          N_CHAN     = 2,
  parameter int          FIFO_DEPTH = 16,
  parameter int          TIMER_DIV  = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           write_address,
  input  logic [31:0]           data_write,
  input  logic [3:0]            write,
  input  logic                  read,
  input  logic [31:0]           read_address,
  output logic [31:0]           data_read,
  output logic                  hit,
  output logic [N_CHAN-1:0]     tx_valid,
  output logic [8*N_CHAN-1:0]   tx_data,
  input  logic [N_CHAN-1:0]     tx_ready,
  output logic                  halt,
  output logic [31:0]           halt_code
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  localparam logic [15:0] OFF_HALT    = 16'h0000;
  localparam logic [15:0] OFF_TX      = 16'h1000;
  localparam logic [15:0] OFF_STATUS  = 16'h5000;
  localparam logic [15:0] OFF_TIME_LO = 16'h6000;
  localparam logic [15:0] OFF_TIME_HI = 16'h6004;

  logic        wr_sel;
  logic [15:0] wr_off;
  logic [15:0] rd_off;
  logic        halt_wr;
  logic        status_wr;
  logic        time_lo_rd;

  logic [N_CHAN-1:0] push;
  logic [N_CHAN-1:0] full;
  logic [N_CHAN-1:0] ovf;
  logic [N_CHAN-1:0] not_empty;
  logic [31:0]       status;

  logic [PW-1:0] prescaler;
  logic [63:0]   tick;
  logic [31:0]   hi_snap;
  logic          prescale_wrap;

  assign wr_sel     = (write != 4'b0000) && (write_address[31:16] == BASE_ADDR[31:16]);
  assign wr_off     = write_address[15:0];
  assign rd_off     = read_address[15:0];
  assign hit        = read && (read_address[31:16] == BASE_ADDR[31:16]);
  assign halt_wr    = wr_sel && (wr_off == OFF_HALT);
  assign status_wr  = wr_sel && (wr_off == OFF_STATUS);
  assign time_lo_rd = hit && (rd_off == OFF_TIME_LO);

  genvar g;
  generate
    for (g = 0; g < N_CHAN; g++) begin : g_chan
      logic [7:0]    mem [FIFO_DEPTH];
      logic [AW-1:0] wr_ptr;
      logic [AW-1:0] rd_ptr;
      logic [CW-1:0] count;
      logic          pop;
      logic          accept;

      assign push[g]      = wr_sel && write[0] && (wr_off == OFF_TX + 16'(4 * g));
      assign full[g]      = (count == CW'(FIFO_DEPTH));
      assign not_empty[g] = (count != '0);
      assign pop          = not_empty[g] && tx_ready[g];
      // A full FIFO still takes a push when the head leaves on the same edge.
      assign accept       = push[g] && (!full[g] || pop);

      assign tx_valid[g]        = not_empty[g];
      assign tx_data[8*g +: 8]  = not_empty[g] ? mem[rd_ptr] : 8'h00;

      always_ff @(posedge clk) begin
        if (!reset && accept) begin
          mem[wr_ptr] <= data_write[7:0];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (accept) begin
            wr_ptr <= wr_ptr + AW'(1);
          end
          if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
          end
          case ({accept, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
          endcase
        end
      end

      // A same-cycle overflow beats the STATUS clear.
      always_ff @(posedge clk) begin
        if (reset) begin
          ovf[g] <= 1'b0;
        end else if (push[g] && full[g] && !pop) begin
          ovf[g] <= 1'b1;
        end else if (status_wr) begin
          ovf[g] <= 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    status = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      status[c]      = full[c];
      status[8 + c]  = ovf[c];
      status[16 + c] = not_empty[c];
    end
  end

  assign prescale_wrap = (prescaler == PW'(TIMER_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      tick      <= '0;
    end else if (prescale_wrap) begin
      prescaler <= '0;
      tick      <= tick + 64'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // High word is frozen when the low word is read so the pair is coherent.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_snap <= '0;
    end else if (time_lo_rd) begin
      hi_snap <= tick[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halt      <= 1'b0;
      halt_code <= '0;
    end else if (halt_wr) begin
      halt      <= 1'b1;
      halt_code <= data_write;
    end
  end

  always_comb begin
    data_read = '0;
    if (hit) begin
      case (rd_off)
        OFF_STATUS:  data_read = status;
        OFF_TIME_LO: data_read = tick[31:0];
        OFF_TIME_HI: data_read = hi_snap;
        default:     data_read = '0;
      endcase
    end
  end

endmodule
